// File: rtl/fetch_queue_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue_unit
// Description : Instruction fetch stage. Holds the PC, issues reads to a
//               synchronous instruction memory (1-cycle latency), tracks the
//               single in-flight fetch and buffers returned instructions in
//               a FIFO presented to decode with a valid/ready handshake.
//               Jumps and taken branches redirect the PC, flush the FIFO
//               and squash the in-flight fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue_unit #(
    parameter int              PC_W     = 10,
    parameter int              INST_W   = 32,
    parameter int              QDEPTH   = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        sel_dir,
    input  logic              flag_branch,
    input  logic [PC_W-1:0]   pc_jump,
    input  logic [PC_W-1:0]   pc_branch,
    output logic              imem_en,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] inst_out,
    output logic [PC_W-1:0]   inst_pc
);

    // Pointer width; the queue depth is a power of two so pointers wrap
    // naturally. The counter needs one extra code to represent "full".
    localparam int                 c_PTR_W      = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int                 c_CNT_W      = $clog2(QDEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH      = c_CNT_W'(QDEPTH);
    localparam logic [1:0]         c_SEL_JUMP   = 2'b01;
    localparam logic [1:0]         c_SEL_BRANCH = 2'b10;

    // PC and in-flight fetch tracking
    logic [PC_W-1:0]    r_pc;
    logic               r_inf_valid;
    logic               r_inf_squash;
    logic [PC_W-1:0]    r_inf_pc;

    // Queue storage and control
    logic [INST_W-1:0]  r_mem_inst [QDEPTH];
    logic [PC_W-1:0]    r_mem_pc   [QDEPTH];
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;

    // Last head presented, shown on the outputs while the queue is empty
    logic [INST_W-1:0]  r_last_inst;
    logic [PC_W-1:0]    r_last_pc;

    logic               w_redirect;
    logic [PC_W-1:0]    w_target;
    logic [c_CNT_W-1:0] w_used;
    logic               w_issue;
    logic               w_push;
    logic               w_pop;
    logic               w_empty;

    // Redirect decode: jump always, branch only when its condition holds;
    // code 11 falls through to sequential.
    always_comb begin
        w_redirect = 1'b0;
        w_target   = pc_jump;
        if (sel_dir == c_SEL_JUMP) begin
            w_redirect = 1'b1;
            w_target   = pc_jump;
        end else if ((sel_dir == c_SEL_BRANCH) && flag_branch) begin
            w_redirect = 1'b1;
            w_target   = pc_branch;
        end
    end

    // Issue/push/pop decisions. A slot is reserved for the in-flight fetch
    // so the queue can never overflow. Issue is gated by rst_n so the strobe
    // stays low for the whole reset interval. A returning fetch is dropped
    // if it was squashed earlier or a redirect lands in its return cycle.
    always_comb begin
        w_empty = (r_count == '0);
        w_used  = r_count + c_CNT_W'(r_inf_valid);
        w_issue = rst_n & ~w_redirect & (w_used < c_DEPTH);
        w_push  = r_inf_valid & ~r_inf_squash & ~w_redirect;
        w_pop   = ~w_empty & out_ready;
    end

    // PC register and in-flight slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc         <= RESET_PC;
            r_inf_valid  <= 1'b0;
            r_inf_squash <= 1'b0;
            r_inf_pc     <= '0;
        end else begin
            if (w_redirect) begin
                r_pc <= w_target;
            end else if (w_issue) begin
                r_pc <= r_pc + PC_W'(1);
            end
            r_inf_valid <= w_issue;
            if (w_issue) begin
                r_inf_pc     <= r_pc;
                r_inf_squash <= 1'b0;
            end else begin
                r_inf_squash <= r_inf_squash | w_redirect;
            end
        end
    end

    // Queue storage write; contents need no reset since the count masks them
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_inst[r_wr_ptr] <= imem_rdata;
            r_mem_pc[r_wr_ptr]   <= r_inf_pc;
        end
    end

    // Queue pointers and occupancy; a redirect empties the queue after any
    // head transfer in the same cycle has been taken by decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (w_redirect) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Capture the presented head so the outputs hold it once the queue drains
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_inst <= '0;
            r_last_pc   <= '0;
        end else if (!w_empty) begin
            r_last_inst <= r_mem_inst[r_rd_ptr];
            r_last_pc   <= r_mem_pc[r_rd_ptr];
        end
    end

    // Output drive: live head while occupied, last presented head otherwise
    always_comb begin
        imem_en   = w_issue;
        imem_addr = r_pc;
        out_valid = ~w_empty;
        inst_out  = r_last_inst;
        inst_pc   = r_last_pc;
        if (!w_empty) begin
            inst_out = r_mem_inst[r_rd_ptr];
            inst_pc  = r_mem_pc[r_rd_ptr];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_queue_unit
// Description : Directed self-checking bench for fetch_queue_unit with a
//               1-cycle synchronous memory model returning word = address.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue_unit;

    logic        clk;
    logic        rst_n;
    logic [1:0]  sel_dir;
    logic        flag_branch;
    logic [9:0]  pc_jump;
    logic [9:0]  pc_branch;
    logic        imem_en;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] inst_out;
    logic [9:0]  inst_pc;

    int          n_vec = 0;
    int          n_bad = 0;
    int          n_iss;
    logic [9:0]  iss_addr [8];

    fetch_queue_unit #(
        .PC_W    (10),
        .INST_W  (32),
        .QDEPTH  (4),
        .RESET_PC(10'd0)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sel_dir    (sel_dir),
        .flag_branch(flag_branch),
        .pc_jump    (pc_jump),
        .pc_branch  (pc_branch),
        .imem_en    (imem_en),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .inst_out   (inst_out),
        .inst_pc    (inst_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: word = address one cycle after a strobe, junk otherwise
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= 32'(imem_addr);
        else         imem_rdata <= 32'hDEAD_BEEF;
    end

    task automatic check_vec(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance to the next cycle's sampling point (negedge); inputs set after
    // this call apply to that cycle, then #1 lets combinational outputs settle.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    initial begin
        rst_n       = 1'b0;
        sel_dir     = 2'b00;
        flag_branch = 1'b0;
        pc_jump     = 10'd0;
        pc_branch   = 10'd0;
        out_ready   = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;

        // ---------------- reset state ----------------
        repeat (2) next_cycle();
        #1;
        check_vec("rst_imem_en",   32'(imem_en),   32'd0);
        check_vec("rst_out_valid", 32'(out_valid), 32'd0);
        check_vec("rst_inst_out",  inst_out,       32'd0);
        check_vec("rst_inst_pc",   32'(inst_pc),   32'd0);
        check_vec("rst_imem_addr", 32'(imem_addr), 32'd0);

        // ---------------- streaming from reset ----------------
        next_cycle();
        rst_n = 1'b1;
        #1;
        check_vec("c0_imem_en",   32'(imem_en),   32'd1);
        check_vec("c0_imem_addr", 32'(imem_addr), 32'd0);
        next_cycle(); #1;
        check_vec("c1_out_valid", 32'(out_valid), 32'd0);
        check_vec("c1_imem_addr", 32'(imem_addr), 32'd1);
        for (int k = 0; k < 4; k++) begin
            next_cycle(); #1;
            check_vec("str_out_valid", 32'(out_valid), 32'd1);
            check_vec("str_inst_pc",   32'(inst_pc),   32'(k));
            check_vec("str_inst_out",  inst_out,       32'(k));
        end

        // ---------------- back-pressure from reset ----------------
        next_cycle();
        rst_n     = 1'b0;
        out_ready = 1'b0;
        #1;
        check_vec("midrst_out_valid", 32'(out_valid), 32'd0);
        check_vec("midrst_imem_en",   32'(imem_en),   32'd0);
        next_cycle();
        rst_n = 1'b1;
        n_iss = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (imem_en) begin
                if (n_iss < 8) iss_addr[n_iss] = imem_addr;
                n_iss++;
            end
            next_cycle();
        end
        #1;
        check_vec("bp_issue_count", 32'(n_iss), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check_vec("bp_issue_addr", 32'(iss_addr[i]), 32'(i));
        end
        check_vec("bp_imem_en",   32'(imem_en),   32'd0);
        check_vec("bp_out_valid", 32'(out_valid), 32'd1);
        check_vec("bp_inst_pc",   32'(inst_pc),   32'd0);
        for (int i = 0; i < 2; i++) begin
            next_cycle(); #1;
            check_vec("bp_hold_pc",  32'(inst_pc), 32'd0);
            check_vec("bp_hold_out", inst_out,     32'd0);
        end

        // ---------------- drain to queue {5,6,7}, then jump ----------------
        next_cycle();
        out_ready = 1'b1;
        repeat (5) next_cycle();
        out_ready = 1'b0;
        #1;
        check_vec("pre_head_pc",   32'(inst_pc),   32'd5);
        check_vec("pre_imem_addr", 32'(imem_addr), 32'd8);
        next_cycle();
        sel_dir = 2'b01;
        pc_jump = 10'h100;
        #1;
        check_vec("jmp_imem_en", 32'(imem_en), 32'd0);
        check_vec("jmp_head_pc", 32'(inst_pc), 32'd5);
        next_cycle();
        sel_dir   = 2'b00;
        out_ready = 1'b1;
        #1;
        check_vec("jmp1_out_valid", 32'(out_valid), 32'd0);
        check_vec("jmp1_hold_pc",   32'(inst_pc),   32'd5);
        check_vec("jmp1_hold_out",  inst_out,       32'd5);
        check_vec("jmp1_imem_en",   32'(imem_en),   32'd1);
        check_vec("jmp1_imem_addr", 32'(imem_addr), 32'h100);
        next_cycle(); #1;
        check_vec("jmp2_out_valid", 32'(out_valid), 32'd0);
        check_vec("jmp2_imem_addr", 32'(imem_addr), 32'h101);
        next_cycle(); #1;
        check_vec("jmp3_out_valid", 32'(out_valid), 32'd1);
        check_vec("jmp3_inst_pc",   32'(inst_pc),   32'h100);
        check_vec("jmp3_inst_out",  inst_out,       32'h100);
        next_cycle(); #1;
        check_vec("jmp4_inst_pc",   32'(inst_pc),   32'h101);
        check_vec("jmp4_imem_addr", 32'(imem_addr), 32'h103);

        // ---------------- branch not taken, then taken with PC wrap ----------------
        next_cycle();
        sel_dir     = 2'b10;
        flag_branch = 1'b0;
        pc_branch   = 10'h3FE;
        #1;
        check_vec("bnt_imem_en",   32'(imem_en),   32'd1);
        check_vec("bnt_imem_addr", 32'(imem_addr), 32'h104);
        check_vec("bnt_inst_pc",   32'(inst_pc),   32'h102);
        next_cycle();
        sel_dir = 2'b00;
        #1;
        check_vec("bnt1_inst_pc", 32'(inst_pc), 32'h103);
        next_cycle();
        sel_dir     = 2'b10;
        flag_branch = 1'b1;
        #1;
        check_vec("bt_imem_en", 32'(imem_en), 32'd0);
        check_vec("bt_inst_pc", 32'(inst_pc), 32'h104);
        next_cycle();
        sel_dir     = 2'b00;
        flag_branch = 1'b0;
        #1;
        check_vec("bt1_out_valid", 32'(out_valid), 32'd0);
        check_vec("bt1_hold_pc",   32'(inst_pc),   32'h104);
        check_vec("bt1_imem_addr", 32'(imem_addr), 32'h3FE);
        next_cycle(); #1;
        check_vec("bt2_out_valid", 32'(out_valid), 32'd0);
        check_vec("bt2_imem_addr", 32'(imem_addr), 32'h3FF);
        next_cycle(); #1;
        check_vec("bt3_inst_pc",   32'(inst_pc),   32'h3FE);
        check_vec("bt3_imem_addr", 32'(imem_addr), 32'h000);
        next_cycle();
        sel_dir = 2'b11;
        pc_jump = 10'h055;
        #1;
        check_vec("sel11_imem_en",   32'(imem_en),   32'd1);
        check_vec("sel11_imem_addr", 32'(imem_addr), 32'h001);
        check_vec("bt4_inst_pc",     32'(inst_pc),   32'h3FF);
        next_cycle();
        sel_dir = 2'b00;
        #1;
        check_vec("wrap_inst_pc",  32'(inst_pc), 32'h000);
        check_vec("wrap_inst_out", inst_out,     32'h000);

        // ---------------- fill, then one-cycle reset pulse ----------------
        next_cycle();
        out_ready = 1'b0;
        repeat (6) next_cycle();
        #1;
        check_vec("full_imem_en",   32'(imem_en),   32'd0);
        check_vec("full_out_valid", 32'(out_valid), 32'd1);
        check_vec("full_inst_pc",   32'(inst_pc),   32'd1);
        next_cycle();
        rst_n = 1'b0;
        #1;
        check_vec("pulse_out_valid", 32'(out_valid), 32'd0);
        check_vec("pulse_imem_en",   32'(imem_en),   32'd0);
        check_vec("pulse_inst_pc",   32'(inst_pc),   32'd0);
        check_vec("pulse_inst_out",  inst_out,       32'd0);
        next_cycle();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        check_vec("rstrt_imem_en",   32'(imem_en),   32'd1);
        check_vec("rstrt_imem_addr", 32'(imem_addr), 32'd0);
        next_cycle(); #1;
        check_vec("rstrt1_out_valid", 32'(out_valid), 32'd0);
        next_cycle(); #1;
        check_vec("rstrt2_out_valid", 32'(out_valid), 32'd1);
        check_vec("rstrt2_inst_pc",   32'(inst_pc),   32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
